// File: rtl/irq_cmd_master_pkg.sv
// Shared encodings, field layout and state types for the irqctrl command-port master.
package irq_cmd_master_pkg;

    typedef enum logic [1:0] {
        CMDDEVRDY = 2'b00,
        CMDACKIRQ = 2'b01,
        CMDINTDST = 2'b10,
        CMDENAIRQ = 2'b11
    } irq_cmd_e;

    localparam int CMD_LSB = 0;
    localparam int CMD_W   = 2;
    localparam int EN_BIT  = 2;
    localparam int IDX_LSB = 3;

    // Sentinels live at the widest supported arg width; users keep the low bits.
    localparam int                  MAX_ARGW   = 62;
    localparam logic [MAX_ARGW-1:0] SRC_INTDST = {MAX_ARGW{1'b1}};
    localparam logic [MAX_ARGW-1:0] SRC_NONE   = {{(MAX_ARGW-1){1'b1}}, 1'b0};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_P1RD,
        ST_P1WR,
        ST_P1CHK,
        ST_P2RD,
        ST_P2WR,
        ST_DONE
    } cmd_state_e;

    typedef enum logic [1:0] {
        BT_IDLE,
        BT_REQ,
        BT_WAIT
    } beat_state_e;

    function automatic logic is_devrdy(input logic [CMD_W-1:0] status);
        return status == CMDDEVRDY;
    endfunction

endpackage

// File: rtl/irq_cmd_master_wb_beat_master.sv
// Single wishbone beat: holds stb until accepted (!bsy), then waits for ack.
module irq_cmd_master_wb_beat_master
    import irq_cmd_master_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          start,
    input  logic          we,
    input  logic [DW-1:0] wdat,
    output logic          stb,
    output logic          we_q,
    output logic [DW-1:0] dat_q,
    input  logic          bsy,
    input  logic          ack,
    input  logic [DW-1:0] dat_in,
    output logic          done,
    output logic [DW-1:0] rdat
);

    beat_state_e bstate;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bstate <= BT_IDLE;
            stb    <= 1'b0;
            we_q   <= 1'b0;
            dat_q  <= '0;
            done   <= 1'b0;
            rdat   <= '0;
        end else begin
            done <= 1'b0;
            case (bstate)
                BT_IDLE: begin
                    if (start) begin
                        stb    <= 1'b1;
                        we_q   <= we;
                        dat_q  <= wdat;
                        bstate <= BT_REQ;
                    end
                end
                BT_REQ: begin
                    if (!bsy) begin
                        stb <= 1'b0;
                        // A zero-wait slave may ack on the accepting edge.
                        if (ack) begin
                            done   <= 1'b1;
                            bstate <= BT_IDLE;
                            if (!we_q) rdat <= dat_in;
                        end else begin
                            bstate <= BT_WAIT;
                        end
                    end
                end
                BT_WAIT: begin
                    if (ack) begin
                        done   <= 1'b1;
                        bstate <= BT_IDLE;
                        if (!we_q) rdat <= dat_in;
                    end
                end
                default: bstate <= BT_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/irq_cmd_master.sv
// Drives the interrupt controller's two-phase atomic command protocol for a local
// requester or, in auto-ack mode, for this destination's own irq strobe.
module irq_cmd_master
    import irq_cmd_master_pkg::*;
#(
    parameter int ARCHBITSZ = 16,
    parameter int CTRLADDR  = 0,
    parameter int DSTIDX    = 0,
    parameter int MAXRETRY  = 15,
    parameter int AUTOACK   = 1
) (
    input  logic                                        clk_i,
    input  logic                                        rst_ni,
    output logic                                        wb_cyc_o,
    output logic                                        wb_stb_o,
    output logic                                        wb_we_o,
    output logic [ARCHBITSZ-$clog2(ARCHBITSZ/8)-1:0]    wb_addr_o,
    output logic [ARCHBITSZ/8-1:0]                      wb_sel_o,
    output logic [ARCHBITSZ-1:0]                        wb_dat_o,
    input  logic                                        wb_bsy_i,
    input  logic                                        wb_ack_i,
    input  logic [ARCHBITSZ-1:0]                        wb_dat_i,
    input  logic                                        req_stb_i,
    input  logic [1:0]                                  req_cmd_i,
    input  logic [ARCHBITSZ-3:0]                        req_arg_i,
    output logic                                        req_rdy_o,
    output logic                                        rsp_stb_o,
    output logic [ARCHBITSZ-1:0]                        rsp_dat_o,
    output logic                                        rsp_err_o,
    input  logic                                        irq_stb_i,
    output logic                                        irq_rdy_o,
    output logic                                        irq_src_stb_o,
    output logic [ARCHBITSZ-3:0]                        irq_src_o
);

    localparam int AW   = ARCHBITSZ - $clog2(ARCHBITSZ/8);
    localparam int ARGW = ARCHBITSZ - 2;
    localparam logic [ARCHBITSZ-1:0] ACK_WORD = (ARCHBITSZ'(DSTIDX) << IDX_LSB)
                                              | (ARCHBITSZ'(1) << EN_BIT)
                                              | ARCHBITSZ'(CMDACKIRQ);

    cmd_state_e           state;
    logic [ARCHBITSZ-1:0] word;
    logic                 is_irq;
    logic                 err_flag;
    logic [7:0]           retry_cnt;
    logic [7:0]           retry_nxt;
    logic                 beat_start;
    logic                 beat_we;
    logic [ARCHBITSZ-1:0] beat_wdat;
    logic                 beat_done;
    logic [ARCHBITSZ-1:0] beat_rdat;

    assign wb_addr_o = AW'(CTRLADDR);
    assign wb_sel_o  = '1;
    assign retry_nxt = retry_cnt + 8'd1;

    irq_cmd_master_wb_beat_master #(.DW(ARCHBITSZ)) u_beat (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .start  (beat_start),
        .we     (beat_we),
        .wdat   (beat_wdat),
        .stb    (wb_stb_o),
        .we_q   (wb_we_o),
        .dat_q  (wb_dat_o),
        .bsy    (wb_bsy_i),
        .ack    (wb_ack_i),
        .dat_in (wb_dat_i),
        .done   (beat_done),
        .rdat   (beat_rdat)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state         <= ST_IDLE;
            word          <= '0;
            is_irq        <= 1'b0;
            err_flag      <= 1'b0;
            retry_cnt     <= '0;
            beat_start    <= 1'b0;
            beat_we       <= 1'b0;
            beat_wdat     <= '0;
            wb_cyc_o      <= 1'b0;
            req_rdy_o     <= 1'b1;
            rsp_stb_o     <= 1'b0;
            rsp_dat_o     <= '0;
            rsp_err_o     <= 1'b0;
            irq_rdy_o     <= 1'b1;
            irq_src_stb_o <= 1'b0;
            irq_src_o     <= '0;
        end else begin
            beat_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // First idle cycle after DONE retires the pulses and reopens both ports.
                    rsp_stb_o     <= 1'b0;
                    irq_src_stb_o <= 1'b0;
                    req_rdy_o     <= 1'b1;
                    irq_rdy_o     <= 1'b1;
                    if (AUTOACK != 0 && irq_stb_i && irq_rdy_o && req_rdy_o) begin
                        word       <= ACK_WORD;
                        is_irq     <= 1'b1;
                        irq_rdy_o  <= 1'b0;
                        req_rdy_o  <= 1'b0;
                        wb_cyc_o   <= 1'b1;
                        beat_start <= 1'b1;
                        beat_we    <= 1'b0;
                        state      <= ST_P1RD;
                    end else if (req_stb_i && req_rdy_o) begin
                        word       <= {req_arg_i, req_cmd_i};
                        is_irq     <= 1'b0;
                        req_rdy_o  <= 1'b0;
                        wb_cyc_o   <= 1'b1;
                        beat_start <= 1'b1;
                        beat_we    <= 1'b0;
                        state      <= ST_P1RD;
                    end
                end
                ST_P1RD: begin
                    if (beat_done) begin
                        beat_start <= 1'b1;
                        beat_we    <= 1'b1;
                        beat_wdat  <= word;
                        state      <= ST_P1WR;
                    end
                end
                ST_P1WR: begin
                    if (beat_done) begin
                        wb_cyc_o <= 1'b0;
                        state    <= ST_P1CHK;
                    end
                end
                ST_P1CHK: begin
                    if (is_devrdy(beat_rdat[CMD_LSB +: CMD_W])) begin
                        wb_cyc_o   <= 1'b1;
                        beat_start <= 1'b1;
                        beat_we    <= 1'b0;
                        state      <= ST_P2RD;
                    end else begin
                        retry_cnt <= retry_nxt;
                        if (retry_nxt == 8'(MAXRETRY)) begin
                            err_flag <= 1'b1;
                            state    <= ST_DONE;
                        end else begin
                            wb_cyc_o   <= 1'b1;
                            beat_start <= 1'b1;
                            beat_we    <= 1'b0;
                            state      <= ST_P1RD;
                        end
                    end
                end
                ST_P2RD: begin
                    if (beat_done) begin
                        rsp_dat_o  <= beat_rdat;
                        beat_start <= 1'b1;
                        beat_we    <= 1'b1;
                        beat_wdat  <= ARCHBITSZ'(CMDDEVRDY);
                        state      <= ST_P2WR;
                    end
                end
                ST_P2WR: begin
                    if (beat_done) begin
                        wb_cyc_o <= 1'b0;
                        state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (is_irq) begin
                        irq_src_stb_o <= 1'b1;
                        irq_src_o     <= err_flag ? SRC_NONE[ARGW-1:0]
                                                  : rsp_dat_o[ARCHBITSZ-1:CMD_W];
                    end else begin
                        rsp_stb_o <= 1'b1;
                        rsp_err_o <= err_flag;
                    end
                    retry_cnt <= '0;
                    err_flag  <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_irq_cmd_master.sv
// Directed bench for irq_cmd_master: one instance against a scripted controller model,
// a second with MAXRETRY=2 against a controller that never becomes ready.
module tb_irq_cmd_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b1;
    logic rst_n_b = 1'b1;

    // instance A
    logic        cyc, stb, we, bsy, ack;
    logic [14:0] addr;
    logic [1:0]  sel;
    logic [15:0] dat_o, dat_i;
    logic        req_stb, req_rdy, rsp_stb, rsp_err, irq_stb, irq_rdy, irq_src_stb;
    logic [1:0]  req_cmd;
    logic [13:0] req_arg, irq_src;
    logic [15:0] rsp_dat;

    // instance B
    logic        cyc_b, stb_b, we_b, ack_b;
    logic [14:0] addr_b;
    logic [1:0]  sel_b;
    logic [15:0] dat_o_b;
    logic        req_stb_b, req_rdy_b, rsp_stb_b, rsp_err_b, irq_rdy_b, irq_src_stb_b;
    logic [1:0]  req_cmd_b;
    logic [13:0] req_arg_b, irq_src_b;
    logic [15:0] rsp_dat_b;

    irq_cmd_master #(.ARCHBITSZ(16), .CTRLADDR(0), .DSTIDX(0), .MAXRETRY(15), .AUTOACK(1)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .wb_cyc_o(cyc), .wb_stb_o(stb), .wb_we_o(we), .wb_addr_o(addr), .wb_sel_o(sel),
        .wb_dat_o(dat_o), .wb_bsy_i(bsy), .wb_ack_i(ack), .wb_dat_i(dat_i),
        .req_stb_i(req_stb), .req_cmd_i(req_cmd), .req_arg_i(req_arg), .req_rdy_o(req_rdy),
        .rsp_stb_o(rsp_stb), .rsp_dat_o(rsp_dat), .rsp_err_o(rsp_err),
        .irq_stb_i(irq_stb), .irq_rdy_o(irq_rdy), .irq_src_stb_o(irq_src_stb), .irq_src_o(irq_src)
    );

    irq_cmd_master #(.ARCHBITSZ(16), .CTRLADDR(0), .DSTIDX(0), .MAXRETRY(2), .AUTOACK(0)) dut_b (
        .clk_i(clk), .rst_ni(rst_n_b),
        .wb_cyc_o(cyc_b), .wb_stb_o(stb_b), .wb_we_o(we_b), .wb_addr_o(addr_b), .wb_sel_o(sel_b),
        .wb_dat_o(dat_o_b), .wb_bsy_i(1'b0), .wb_ack_i(ack_b), .wb_dat_i(16'h0001),
        .req_stb_i(req_stb_b), .req_cmd_i(req_cmd_b), .req_arg_i(req_arg_b), .req_rdy_o(req_rdy_b),
        .rsp_stb_o(rsp_stb_b), .rsp_dat_o(rsp_dat_b), .rsp_err_o(rsp_err_b),
        .irq_stb_i(1'b0), .irq_rdy_o(irq_rdy_b), .irq_src_stb_o(irq_src_stb_b), .irq_src_o(irq_src_b)
    );

    // Controller model A: scripted read data, bsy for bsy_cfg cycles per beat, ack 2 cycles after accept.
    logic        mclr = 1'b1;
    int          bsy_cfg = 0;
    logic [15:0] rd_tbl [8];
    logic [15:0] wr_log [16];
    int          rd_idx, acc_cnt, bsy_seen, wr_cnt, rises, gap_err, busy_cnt;
    logic        prev_cyc, low_since_rd, m_dly, m_ack;
    logic [15:0] m_rdat;

    assign bsy   = stb && cyc && (busy_cnt != 0);
    assign ack   = m_ack;
    assign dat_i = m_rdat;

    always @(posedge clk) begin
        if (mclr) begin
            rd_idx <= 0; acc_cnt <= 0; bsy_seen <= 0; wr_cnt <= 0; rises <= 0; gap_err <= 0;
            busy_cnt <= bsy_cfg; prev_cyc <= cyc; low_since_rd <= 1'b0;
            m_dly <= 1'b0; m_ack <= 1'b0; m_rdat <= '0;
        end else begin
            m_ack    <= m_dly;
            m_dly    <= 1'b0;
            prev_cyc <= cyc;
            if (cyc && !prev_cyc) rises <= rises + 1;
            if (!cyc) low_since_rd <= 1'b1;
            if (cyc && stb) begin
                if (busy_cnt != 0) begin
                    busy_cnt <= busy_cnt - 1;
                    bsy_seen <= bsy_seen + 1;
                end else begin
                    acc_cnt  <= acc_cnt + 1;
                    m_dly    <= 1'b1;
                    busy_cnt <= bsy_cfg;
                    if (we) begin
                        if (low_since_rd) gap_err <= gap_err + 1;
                        if (wr_cnt < 16) wr_log[wr_cnt[3:0]] <= dat_o;
                        wr_cnt <= wr_cnt + 1;
                    end else begin
                        low_since_rd <= 1'b0;
                        m_rdat <= rd_tbl[rd_idx[2:0]];
                        rd_idx <= rd_idx + 1;
                    end
                end
            end
        end
    end

    // Controller model B: never ready (status cmd field 01), ack one cycle after accept.
    int          wr_b, rd_b, rises_b;
    logic        prev_cyc_b;
    logic [15:0] last_wr_b;

    always @(posedge clk) begin
        if (mclr) begin
            wr_b <= 0; rd_b <= 0; rises_b <= 0; ack_b <= 1'b0; prev_cyc_b <= cyc_b; last_wr_b <= '0;
        end else begin
            ack_b      <= cyc_b && stb_b;
            prev_cyc_b <= cyc_b;
            if (cyc_b && !prev_cyc_b) rises_b <= rises_b + 1;
            if (cyc_b && stb_b) begin
                if (we_b) begin
                    wr_b      <= wr_b + 1;
                    last_wr_b <= dat_o_b;
                end else begin
                    rd_b <= rd_b + 1;
                end
            end
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_model();
        mclr = 1'b1;
        tick();
        mclr = 1'b0;
    endtask

    task automatic wait_rsp(input int lim, output logic seen);
        seen = 1'b0;
        for (int i = 0; i < lim && !seen; i++) begin
            tick();
            if (rsp_stb) seen = 1'b1;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen, flag, flag2;
        req_stb = 1'b0; req_cmd = '0; req_arg = '0; irq_stb = 1'b0;
        req_stb_b = 1'b0; req_cmd_b = '0; req_arg_b = '0;
        for (int i = 0; i < 8; i++) rd_tbl[i] = '0;
        #1 rst_n = 1'b0; rst_n_b = 1'b0;
        #11;
        chk("rst_cyc", 32'(cyc), 0);
        chk("rst_stb", 32'(stb), 0);
        chk("rst_we", 32'(we), 0);
        chk("rst_dat", 32'(dat_o), 0);
        chk("rst_sel", 32'(sel), 32'h3);
        chk("rst_addr", 32'(addr), 0);
        chk("rst_req_rdy", 32'(req_rdy), 1);
        chk("rst_rsp_stb", 32'(rsp_stb), 0);
        chk("rst_rsp_dat", 32'(rsp_dat), 0);
        chk("rst_rsp_err", 32'(rsp_err), 0);
        chk("rst_irq_rdy", 32'(irq_rdy), 1);
        chk("rst_irq_src_stb", 32'(irq_src_stb), 0);
        chk("rst_irq_src", 32'(irq_src), 0);
        chk("rst_b_addr", 32'(addr_b), 0);
        chk("rst_b_sel", 32'(sel_b), 32'h3);
        chk("rst_b_irq_rdy", 32'(irq_rdy_b), 1);
        chk("rst_b_irq_src", 32'({irq_src_stb_b, irq_src_b}), 0);
        chk("rst_b_req_rdy", 32'(req_rdy_b), 1);
        @(posedge clk); #1;
        rst_n = 1'b1; rst_n_b = 1'b1;
        tick();

        // enable source 3: word 0x001F, then 0x0000; result 0x000F
        rd_tbl[0] = 16'h0000; rd_tbl[1] = 16'h000F;
        clr_model();
        req_cmd = 2'b11; req_arg = 14'h7; req_stb = 1'b1;
        tick();
        chk("en_req_rdy_low", 32'(req_rdy), 0);
        req_stb = 1'b0;
        wait_rsp(200, seen);
        chk("en_rsp_seen", 32'(seen), 1);
        chk("en_rsp_dat", 32'(rsp_dat), 32'h000F);
        chk("en_rsp_err", 32'(rsp_err), 0);
        chk("en_wr_cnt", wr_cnt, 2);
        chk("en_wr0", 32'(wr_log[0]), 32'h001F);
        chk("en_wr1", 32'(wr_log[1]), 32'h0000);
        chk("en_pairs", rises, 2);
        tick();
        chk("en_rsp_stb_1cyc", 32'(rsp_stb), 0);
        chk("en_req_rdy_back", 32'(req_rdy), 1);

        // busy controller: two not-ready statuses, then ready
        rd_tbl[0] = 16'h0001; rd_tbl[1] = 16'h0001; rd_tbl[2] = 16'h0000; rd_tbl[3] = 16'h0023;
        clr_model();
        req_cmd = 2'b10; req_arg = 14'h12; req_stb = 1'b1;
        tick();
        req_stb = 1'b0;
        wait_rsp(400, seen);
        chk("busy_rsp_seen", 32'(seen), 1);
        chk("busy_rsp_dat", 32'(rsp_dat), 32'h0023);
        chk("busy_rsp_err", 32'(rsp_err), 0);
        chk("busy_pairs", rises, 4);
        chk("busy_wr_cnt", wr_cnt, 4);
        for (int i = 0; i < 3; i++) chk($sformatf("busy_p1_wr%0d", i), 32'(wr_log[i]), 32'h004A);
        chk("busy_p2_wr", 32'(wr_log[3]), 32'h0000);
        tick();

        // auto-ack: source 5 pending
        rd_tbl[0] = 16'h0000; rd_tbl[1] = 16'h0015;
        clr_model();
        irq_stb = 1'b1;
        tick();
        chk("aa_irq_rdy_low", 32'(irq_rdy), 0);
        irq_stb = 1'b0;
        seen = 1'b0; flag = 1'b0; flag2 = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            tick();
            if (irq_src_stb) seen = 1'b1;
            else if (irq_rdy) flag = 1'b1;
            if (rsp_stb) flag2 = 1'b1;
        end
        chk("aa_src_stb_seen", 32'(seen), 1);
        chk("aa_src", 32'(irq_src), 32'h5);
        chk("aa_irq_rdy_during", 32'({flag, irq_rdy}), 0);
        chk("aa_no_rsp_stb", 32'(flag2), 0);
        chk("aa_wr0", 32'(wr_log[0]), 32'h0005);
        chk("aa_wr1", 32'(wr_log[1]), 32'h0000);
        tick();
        chk("aa_irq_rdy_after", 32'(irq_rdy), 1);
        chk("aa_src_stb_1cyc", 32'(irq_src_stb), 0);

        // irq and req in the same cycle: irq first
        rd_tbl[0] = 16'h0000; rd_tbl[1] = 16'h0009; rd_tbl[2] = 16'h0000; rd_tbl[3] = 16'h00AB;
        clr_model();
        req_cmd = 2'b01; req_arg = 14'h3; req_stb = 1'b1; irq_stb = 1'b1;
        tick();
        chk("sim_rdys_low", 32'({irq_rdy, req_rdy}), 0);
        irq_stb = 1'b0;
        seen = 1'b0; flag = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            tick();
            if (req_rdy) flag = 1'b1;
            if (irq_src_stb) seen = 1'b1;
        end
        chk("sim_irq_first", 32'(seen), 1);
        chk("sim_irq_src", 32'(irq_src), 32'h2);
        chk("sim_req_rdy_held_low", 32'(flag), 0);
        chk("sim_irq_wr0", 32'(wr_log[0]), 32'h0005);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            if (req_rdy) seen = 1'b1;
        end
        chk("sim_req_rdy_returns", 32'(seen), 1);
        tick();
        req_stb = 1'b0;
        wait_rsp(200, seen);
        chk("sim_rsp_seen", 32'(seen), 1);
        chk("sim_rsp_dat", 32'(rsp_dat), 32'h00AB);
        chk("sim_req_wr", 32'(wr_log[2]), 32'h000D);
        chk("sim_wr_cnt", wr_cnt, 4);
        tick();

        // bsy held 3 cycles on every beat
        bsy_cfg = 3;
        rd_tbl[0] = 16'h0000; rd_tbl[1] = 16'h0042;
        clr_model();
        req_cmd = 2'b00; req_arg = 14'h1; req_stb = 1'b1;
        tick();
        req_stb = 1'b0;
        wait_rsp(400, seen);
        chk("bsy_rsp_seen", 32'(seen), 1);
        chk("bsy_stb_bsy_cycles", bsy_seen, 12);
        chk("bsy_accepts", acc_cnt, 4);
        chk("bsy_cyc_gap_in_pair", gap_err, 0);
        chk("bsy_pairs", rises, 2);
        chk("bsy_rsp_dat", 32'(rsp_dat), 32'h0042);
        chk("bsy_wr0", 32'(wr_log[0]), 32'h0004);
        bsy_cfg = 0;
        tick();

        // reset pulse during P2RD
        rd_tbl[0] = 16'h0000; rd_tbl[1] = 16'h0055;
        clr_model();
        req_cmd = 2'b11; req_arg = 14'h2; req_stb = 1'b1;
        tick();
        req_stb = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            tick();
            if (rises == 2) seen = 1'b1;
        end
        chk("rstp_reached_p2", 32'(seen), 1);
        chk("rstp_cyc_before", 32'(cyc), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rstp_cyc_async", 32'(cyc), 0);
        chk("rstp_stb_async", 32'(stb), 0);
        tick();
        rst_n = 1'b1;
        flag = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (rsp_stb) flag = 1'b1;
        end
        chk("rstp_no_rsp", 32'(flag), 0);
        chk("rstp_req_rdy", 32'(req_rdy), 1);
        chk("rstp_cyc_idle", 32'(cyc), 0);

        // MAXRETRY=2, controller never ready
        clr_model();
        req_cmd_b = 2'b10; req_arg_b = 14'h4; req_stb_b = 1'b1;
        tick();
        req_stb_b = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            tick();
            if (rsp_stb_b) seen = 1'b1;
        end
        chk("mr_rsp_seen", 32'(seen), 1);
        chk("mr_rsp_err", 32'(rsp_err_b), 1);
        chk("mr_pairs", rises_b, 2);
        chk("mr_reads", rd_b, 2);
        chk("mr_writes", wr_b, 2);
        chk("mr_last_wr", 32'(last_wr_b), 32'h0012);
        chk("mr_rsp_dat", 32'(rsp_dat_b), 0);
        tick();
        chk("mr_rsp_stb_1cyc", 32'(rsp_stb_b), 0);
        chk("mr_err_held", 32'(rsp_err_b), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
